i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//  - Synthesizable I2C slave (responder) with internal byte register file; the target-side counterpart of i2c_master_top.
//  - Oversamples SCL/SDA on wb_clk_i, decodes START/STOP, matches 7-bit address, ACKs, accepts writes / serves reads.
//  - Replaces the behavioural slave model in system-level benches; later exposed as a local register block.
// PARAMETERS
//  - SLAVE_ADR  7'h10  7-bit I2C address responded to
//  - DEPTH_LOG2 3      register file depth = 2**DEPTH_LOG2 bytes
//  - RST_VAL    8'h00  reset value of every register file byte
// PORTS
//  - wb_clk_i      in   1  system clock; >= 8x SCL frequency
//  - arst_i        in   1  asynchronous reset, active-low
//  - scl_pad_i     in   1  SCL line input
//  - sda_pad_i     in   1  SDA line input
//  - sda_pad_o     out  1  SDA output value, constant 1'b0
//  - sda_padoen_o  out  1  SDA output enable, active-low (0 = pull SDA low)
//  - busy_o        out  1  1 from address match until STOP / NACKed read / non-matching address
//  - wr_stb_o      out  1  one-cycle pulse per data byte written into register file
//  - wr_adr_o      out  DEPTH_LOG2  register index of that write (valid with wr_stb_o)
//  - wr_dat_o      out  8  data of that write (valid with wr_stb_o)
// BEHAVIOUR
//  - Reset (arst_i=0): sda_padoen_o=1, busy_o=0, wr_stb_o=0, wr_adr_o=0, wr_dat_o=0, pointer=0, regs=RST_VAL, state IDLE.
//  - Inputs pass a 2-flop synchronizer; edges detected on synchronized values (prev vs current).
//  - START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both recognised in every state.
//  - START (incl. repeated) -> ADDR, bit count 0, release SDA. STOP -> IDLE, release SDA, busy_o=0.
//  - Data bits sampled on SCL rising edge, MSB first; SDA driven/changed only after SCL falling edge.
//  - SDA drive latency: sda_padoen_o changes 3 wb_clk_i cycles after SCL falls at pin (4 with filter).
//  - States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
//  - ADDR: 8 bits shifted; on 8th SCL fall: adr[7:1]==SLAVE_ADR -> ADDR_ACK (drive 0, busy_o=1); else WAIT_STOP.
//  - ADDR_ACK: at next SCL fall release; R/W=0 -> RX (first byte = pointer); R/W=1 -> TX, load regs[ptr].
//  - RX: 8 bits; 8th SCL fall -> RX_ACK, drive 0. First byte after address: ptr=byte[DEPTH_LOG2-1:0] (upper bits ignored).
//    Later bytes: regs[ptr]=byte, wr_stb_o pulse with wr_adr_o=ptr, ptr=ptr+1. Write committed at ACK drive.
//  - RX_ACK: release at next SCL fall -> RX. Slave always ACKs written bytes.
//  - TX: shift out regs[ptr] MSB first (bit 1 -> release, bit 0 -> drive); after 8th bit release -> TX_ACK, ptr=ptr+1.
//  - TX_ACK: master ACK (SDA=0 at SCL rise) -> TX, load regs[ptr]; NACK -> WAIT_STOP, busy_o=0.
//  - WAIT_STOP: SDA released; only START/STOP leave it.
//  - Pointer wraps DEPTH-1 -> 0 for reads and writes; persists across transactions (read w/o pointer write continues).
//  - START/STOP mid-byte: partial byte discarded, no write, no wr_stb_o; pointer unchanged.
//  - Reset mid-transfer: SDA released within reset assertion; bus recovers on next START.
//  - Never drives SCL (no clock stretching).
// CONFIGURATION
//  - I2C_SLAVE_GLITCH_FILTER_EN defined: 3-sample majority filter after synchronizer on SCL and SDA.
//    Pulses <= 1 wb_clk_i cycle ignored; all input-derived latencies +1 cycle.
//  - Undefined: no filter; synchronizer outputs used directly.
// TESTING
//  - Write 8'h20,{3'h3},8'hA5,8'h5A -> ACK each byte; wr_stb_o twice: (3,A5),(4,5A).
//  - Write ptr 3, repeated START, read 2 bytes (ACK,NACK) -> SDA shows A5,5A; busy_o falls after NACK.
//  - Address 7'h11 -> no ACK (SDA stays 1), WAIT_STOP, busy_o=0, no wr_stb_o.
//  - Write ptr 7, data 11,22 -> regs[7]=11, regs[0]=22 (wrap); readback confirms.
//  - STOP after 4 data bits -> no wr_stb_o; next read at ptr returns prior contents.
//  - arst_i low mid-ACK -> sda_padoen_o=1 immediately; all outputs at reset values.
//  - Filter on: 1-cycle SDA low glitch while SCL high -> no START detected.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C responder at SLAVE_ADR fronting a 2**DEPTH_LOG2-byte register file; optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Latency: sda_padoen_o updates 3 wb_clk_i cycles after SCL falls at the pin (4 with the filter); wr_stb_o fires with the ACK drive.
// Backpressure: none; SCL is never stretched, every written byte is ACKed, wr_stb_o is a single-cycle pulse.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADR  = 7'h10,
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] RST_VAL    = 8'h00
) (
  input  logic                  wb_clk_i,
  input  logic                  arst_i,
  input  logic                  scl_pad_i,
  input  logic                  sda_pad_i,
  output logic                  sda_pad_o,
  output logic                  sda_padoen_o,
  output logic                  busy_o,
  output logic                  wr_stb_o,
  output logic [DEPTH_LOG2-1:0] wr_adr_o,
  output logic [7:0]            wr_dat_o
);
  localparam int DEPTH = 2**DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP} state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_cur, sda_cur, scl_prev, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t                state, state_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic [7:0]            shreg, shreg_nxt;
  logic [6:0]            txreg, txreg_nxt;
  logic [DEPTH_LOG2-1:0] ptr, ptr_nxt;
  logic                  rw, rw_nxt, first, first_nxt;
  logic                  oen, oen_nxt, busy, busy_nxt, wr_en;
  logic [7:0]            regs [DEPTH];

  // Two-flop synchronizers; lines reset to the idle-high bus level.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_pad_i};
      sda_sync <= {sda_sync[0], sda_pad_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  // Two-deep history for the majority vote; a single-cycle pulse never wins two of three votes.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
    end
  end

  assign scl_cur = (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
  assign sda_cur = (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  // Previous line values for edge detection.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  assign scl_rise  = ~scl_prev & scl_cur;
  assign scl_fall  = scl_prev & ~scl_cur;
  assign start_det = scl_cur & sda_prev & ~sda_cur;
  assign stop_det  = scl_cur & ~sda_prev & sda_cur;

  // Protocol FSM and datapath registers.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      txreg    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      first    <= 1'b0;
      oen      <= 1'b1;
      busy     <= 1'b0;
      wr_stb_o <= 1'b0;
      wr_adr_o <= '0;
      wr_dat_o <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      txreg    <= txreg_nxt;
      ptr      <= ptr_nxt;
      rw       <= rw_nxt;
      first    <= first_nxt;
      oen      <= oen_nxt;
      busy     <= busy_nxt;
      wr_stb_o <= wr_en;
      if (wr_en) begin
        wr_adr_o <= ptr;
        wr_dat_o <= shreg;
      end
    end
  end

  // Register file; a byte is committed on the same SCL fall that starts its ACK.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
    end else if (wr_en) begin
      regs[ptr] <= shreg;
    end
  end

  // Next-state logic: START/STOP override everything; bits in on SCL rise, SDA changes on SCL fall.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    txreg_nxt   = txreg;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    first_nxt   = first;
    oen_nxt     = oen;
    busy_nxt    = busy;
    wr_en       = 1'b0;
    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      oen_nxt     = 1'b1;
    end else if (stop_det) begin
      state_nxt = IDLE;
      oen_nxt   = 1'b1;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ADDR, RX: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = {shreg[6:0], sda_cur};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (state == ADDR) begin
              if (shreg[7:1] == SLAVE_ADR) begin
                state_nxt = ADDR_ACK;
                oen_nxt   = 1'b0;
                busy_nxt  = 1'b1;
                rw_nxt    = shreg[0];
              end else begin
                state_nxt = WAIT_STOP;
                busy_nxt  = 1'b0;
              end
            end else begin
              state_nxt = RX_ACK;
              oen_nxt   = 1'b0;
              if (first) begin
                ptr_nxt   = shreg[DEPTH_LOG2-1:0];
                first_nxt = 1'b0;
              end else begin
                wr_en   = 1'b1;
                ptr_nxt = ptr + DEPTH_LOG2'(1);
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            if (rw) begin
              state_nxt = TX;
              txreg_nxt = regs[ptr][6:0];
              oen_nxt   = regs[ptr][7];
            end else begin
              state_nxt = RX;
              first_nxt = 1'b1;
              oen_nxt   = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            state_nxt   = RX;
            bit_cnt_nxt = '0;
            oen_nxt     = 1'b1;
          end
        end
        TX: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_nxt = TX_ACK;
              oen_nxt   = 1'b1;
              ptr_nxt   = ptr + DEPTH_LOG2'(1);
            end else begin
              oen_nxt   = txreg[6];
              txreg_nxt = {txreg[5:0], 1'b1};
            end
          end
        end
        TX_ACK: begin
          // NACK ends the read at once; an ACK reloads on the following fall so SDA only moves with SCL low.
          if (scl_rise && sda_cur) begin
            state_nxt = WAIT_STOP;
            busy_nxt  = 1'b0;
          end else if (scl_fall) begin
            state_nxt   = TX;
            bit_cnt_nxt = '0;
            txreg_nxt   = regs[ptr][6:0];
            oen_nxt     = regs[ptr][7];
          end
        end
        WAIT_STOP: oen_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen;
  assign busy_o       = busy;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master with a write/read scoreboard around i2c_slave_regfile.
// Latency: SCL quarter period is 5 wb_clk_i cycles; all bus edges land on wb_clk_i falling edges.
// Backpressure: none; the master never waits on the DUT, a watchdog bounds the run.
module tb_i2c_slave_regfile;
  localparam int Q = 50;

  logic       wb_clk_i = 1'b0;
  logic       arst_i   = 1'b0;
  logic       scl      = 1'b1;
  logic       sda_m    = 1'b1;
  logic       sda_pad_o, sda_padoen_o, busy_o, wr_stb_o;
  logic [2:0] wr_adr_o;
  logic [7:0] wr_dat_o;
  wire        sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [10:0] exp_wr[$];
  logic [7:0]  exp_rd[$];

  i2c_slave_regfile #(.SLAVE_ADR(7'h10), .DEPTH_LOG2(3), .RST_VAL(8'h00)) dut (
    .wb_clk_i(wb_clk_i), .arst_i(arst_i), .scl_pad_i(scl), .sda_pad_i(sda_line),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o), .busy_o(busy_o),
    .wr_stb_o(wr_stb_o), .wr_adr_o(wr_adr_o), .wr_dat_o(wr_dat_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-strobe scoreboard: every pulse must match the oldest expected (adr,dat).
  always @(negedge wb_clk_i) begin
    if (arst_i && wr_stb_o) begin
      logic        pend;
      logic [10:0] e;
      pend = (exp_wr.size() != 0);
      check("wr_stb_expected", 32'(pend), 32'd1);
      if (pend) begin
        e = exp_wr.pop_front();
        check("wr_adr_dat", 32'({wr_adr_o, wr_dat_o}), 32'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    end
    sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send(input string tag, input logic [7:0] b, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    check(tag, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv(input logic [7:0] exp, input logic mack);
    logic [7:0] d;
    logic       e;
    exp_rd.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      read_bit(e);
      d[i] = e;
    end
    write_bit(mack);
    check("rd_byte", 32'(d), 32'(exp_rd.pop_front()));
  endtask

  initial begin
    logic a;
    // Reset values
    #20;
    check("rst_oen", 32'(sda_padoen_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_stb", 32'(wr_stb_o), 32'd0);
    check("rst_adr", 32'(wr_adr_o), 32'd0);
    check("rst_dat", 32'(wr_dat_o), 32'd0);
    #20; arst_i = 1'b1; #40;

    // Write ptr 3, A5, 5A; address ACK latency measured on the 8th SCL fall
    start_cond();
    for (int i = 7; i >= 1; i--) write_bit(8'h20 >> i);
    sda_m = 1'b0; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
    #22; check("ack_lat_early", 32'(sda_padoen_o), 32'd1);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    #6;  check("ack_lat_mid", 32'(sda_padoen_o), 32'd1);
`else
    #6;  check("ack_lat_mid", 32'(sda_padoen_o), 32'd0);
`endif
    #10; check("ack_lat_late", 32'(sda_padoen_o), 32'd0);
    #12;
    read_bit(a);
    check("addr_ack", 32'(a), 32'd0);
    check("busy_on", 32'(busy_o), 32'd1);
    send("ptr_ack", 8'h03, 1'b0);
    exp_wr.push_back({3'd3, 8'hA5});
    send("dat_ack", 8'hA5, 1'b0);
    exp_wr.push_back({3'd4, 8'h5A});
    send("dat_ack", 8'h5A, 1'b0);
    stop_cond();
    check("busy_after_stop", 32'(busy_o), 32'd0);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);

    // Pointer write, repeated START, read two bytes (ACK then NACK)
    start_cond();
    send("addr_ack", 8'h20, 1'b0);
    send("ptr_ack", 8'h03, 1'b0);
    start_cond();
    send("raddr_ack", 8'h21, 1'b0);
    recv(8'hA5, 1'b0);
    check("busy_mid_read", 32'(busy_o), 32'd1);
    recv(8'h5A, 1'b1);
    check("busy_after_nack", 32'(busy_o), 32'd0);
    stop_cond();

    // Foreign address: no ACK, no busy, no writes
    start_cond();
    send("foreign_nack", 8'h22, 1'b1);
    check("foreign_busy", 32'(busy_o), 32'd0);
    send("foreign_data_nack", 8'h55, 1'b1);
    stop_cond();

    // Pointer wrap on write and read
    start_cond();
    send("addr_ack", 8'h20, 1'b0);
    send("ptr_ack", 8'h07, 1'b0);
    exp_wr.push_back({3'd7, 8'h11});
    send("dat_ack", 8'h11, 1'b0);
    exp_wr.push_back({3'd0, 8'h22});
    send("dat_ack", 8'h22, 1'b0);
    stop_cond();
    start_cond();
    send("addr_ack", 8'h20, 1'b0);
    send("ptr_ack", 8'h07, 1'b0);
    start_cond();
    send("raddr_ack", 8'h21, 1'b0);
    recv(8'h11, 1'b0);
    recv(8'h22, 1'b1);
    stop_cond();

    // STOP after 4 data bits: byte dropped, pointer stays at 2; reads continue from there
    start_cond();
    send("addr_ack", 8'h20, 1'b0);
    send("ptr_ack", 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    stop_cond();
    start_cond();
    send("raddr_ack", 8'h21, 1'b0);
    recv(8'h00, 1'b1);
    stop_cond();
    start_cond();
    send("raddr_ack", 8'h21, 1'b0);
    recv(8'hA5, 1'b1);
    stop_cond();
    check("wr_pending", 32'(exp_wr.size()), 32'd0);

    // Reset while the address ACK is being driven
    start_cond();
    for (int i = 7; i >= 0; i--) write_bit(8'h20 >> i);
    sda_m = 1'b1;
    check("pre_rst_oen", 32'(sda_padoen_o), 32'd0);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    arst_i = 1'b0;
    #2;
    check("mid_rst_oen", 32'(sda_padoen_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_stb", 32'(wr_stb_o), 32'd0);
    check("mid_rst_adr", 32'(wr_adr_o), 32'd0);
    check("mid_rst_dat", 32'(wr_dat_o), 32'd0);
    #18; arst_i = 1'b1; #20;
    stop_cond();
    start_cond();
    send("recover_ack", 8'h20, 1'b0);
    send("ptr_ack", 8'h03, 1'b0);
    start_cond();
    send("raddr_ack", 8'h21, 1'b0);
    recv(8'h00, 1'b1);
    stop_cond();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-cycle SDA low pulse with SCL high must not look like a START
    #100;
    #2; sda_m = 1'b0; #10; sda_m = 1'b1; #8;
    #100;
    scl = 1'b0; #Q;
    send("glitch_no_start", 8'h20, 1'b1);
    check("glitch_busy", 32'(busy_o), 32'd0);
    stop_cond();
`endif

    #200;
    check("wr_final", 32'(exp_wr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
